// File: rtl/wavelet_channel_demux_if.sv
// Bus between the wavelet channel demux and its producer/consumer.
// WAVELET_DEMUX_FRAME_COUNT_EN adds the o_frame_count member.
interface wavelet_channel_demux_if #(
    parameter int unsigned NUM_FILTERS    = 8,
    parameter int unsigned SUM_TRUNCATION = 8
);
    logic [SUM_TRUNCATION-1:0]             i_sample;
    logic                                  i_sample_valid;
    logic [7:0]                            i_channel;
    logic                                  i_auto_scan;
    logic                                  i_frame_ack;
    logic [NUM_FILTERS*SUM_TRUNCATION-1:0] o_channel_data;
    logic [NUM_FILTERS-1:0]                o_channel_fresh;
    logic                                  o_frame_valid;
    logic [7:0]                            o_next_channel;
    logic                                  o_overrun;
    logic                                  o_bad_channel;
`ifdef WAVELET_DEMUX_FRAME_COUNT_EN
    logic [15:0]                           o_frame_count;

    modport master (
        output i_sample, i_sample_valid, i_channel, i_auto_scan, i_frame_ack,
        input  o_channel_data, o_channel_fresh, o_frame_valid, o_next_channel,
               o_overrun, o_bad_channel, o_frame_count
    );
    modport slave (
        input  i_sample, i_sample_valid, i_channel, i_auto_scan, i_frame_ack,
        output o_channel_data, o_channel_fresh, o_frame_valid, o_next_channel,
               o_overrun, o_bad_channel, o_frame_count
    );
`else
    modport master (
        output i_sample, i_sample_valid, i_channel, i_auto_scan, i_frame_ack,
        input  o_channel_data, o_channel_fresh, o_frame_valid, o_next_channel,
               o_overrun, o_bad_channel
    );
    modport slave (
        input  i_sample, i_sample_valid, i_channel, i_auto_scan, i_frame_ack,
        output o_channel_data, o_channel_fresh, o_frame_valid, o_next_channel,
               o_overrun, o_bad_channel
    );
`endif
endinterface

// File: rtl/wavelet_channel_demux.sv
// Scatters a time-multiplexed sample stream into per-channel hold registers
// and presents complete frames; WAVELET_DEMUX_FRAME_COUNT_EN adds a frame counter.
module wavelet_channel_demux #(
    parameter int unsigned NUM_FILTERS    = 8,
    parameter int unsigned SUM_TRUNCATION = 8
) (
    input logic                    clk,
    input logic                    rst,
    wavelet_channel_demux_if.slave bus
);
    localparam int unsigned W = NUM_FILTERS * SUM_TRUNCATION;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

    state_t                 state;
    logic [W-1:0]           data;
    logic [NUM_FILTERS-1:0] fresh;
    logic [NUM_FILTERS-1:0] fresh_base;
    logic [NUM_FILTERS-1:0] fresh_next;
    logic [NUM_FILTERS-1:0] onehot;
    logic [7:0]             ptr;
    logic [7:0]             target;
    logic                   accept;
    logic                   ack;
    logic                   hit;
    logic                   frame_valid;
    logic                   overrun;
    logic                   bad;
`ifdef WAVELET_DEMUX_FRAME_COUNT_EN
    logic [15:0]            frame_count;
`endif

    // An ack clears fresh before the coincident write lands, so that write
    // starts the next frame instead of counting as an overrun.
    always_comb begin
        target     = bus.i_auto_scan ? ptr : bus.i_channel;
        accept     = bus.i_sample_valid && (target < 8'(NUM_FILTERS));
        ack        = (state == FULL) && bus.i_frame_ack;
        onehot     = '0;
        for (int unsigned k = 0; k < NUM_FILTERS; k++) begin
            if (target == 8'(k)) onehot[k] = accept;
        end
        fresh_base = ack ? '0 : fresh;
        fresh_next = fresh_base | onehot;
        hit        = |(fresh_base & onehot);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            data        <= '0;
            fresh       <= '0;
            ptr         <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            bad         <= 1'b0;
`ifdef WAVELET_DEMUX_FRAME_COUNT_EN
            frame_count <= '0;
`endif
        end else begin
            fresh <= fresh_next;
            for (int unsigned k = 0; k < NUM_FILTERS; k++) begin
                if (onehot[k]) data[k*SUM_TRUNCATION +: SUM_TRUNCATION] <= bus.i_sample;
            end
            if (hit) overrun <= 1'b1;
            if (bus.i_sample_valid && !accept) bad <= 1'b1;

            if (!bus.i_auto_scan)
                ptr <= '0;
            else if (accept)
                ptr <= (ptr == 8'(NUM_FILTERS - 1)) ? '0 : ptr + 8'd1;

            case (state)
                EMPTY: begin
                    if (accept) state <= FILLING;
                end
                FILLING: begin
                    if (&fresh_next) begin
                        state       <= FULL;
                        frame_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (ack) begin
                        state       <= accept ? FILLING : EMPTY;
                        frame_valid <= 1'b0;
`ifdef WAVELET_DEMUX_FRAME_COUNT_EN
                        if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
`endif
                    end
                end
                default: begin
                    state       <= EMPTY;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_channel_data  = data;
    assign bus.o_channel_fresh = fresh;
    assign bus.o_frame_valid   = frame_valid;
    assign bus.o_next_channel  = ptr;
    assign bus.o_overrun       = overrun;
    assign bus.o_bad_channel   = bad;
`ifdef WAVELET_DEMUX_FRAME_COUNT_EN
    assign bus.o_frame_count   = frame_count;
`endif
endmodule

// File: tb/tb_wavelet_channel_demux.sv
// Directed self-checking bench for wavelet_channel_demux (8 channels x 8 bits).
module tb_wavelet_channel_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    wavelet_channel_demux_if #(.NUM_FILTERS(8), .SUM_TRUNCATION(8)) bus ();

    wavelet_channel_demux #(.NUM_FILTERS(8), .SUM_TRUNCATION(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_sample_valid = 1'b0;
        bus.i_frame_ack    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.i_sample = '0; bus.i_channel = '0; bus.i_auto_scan = 1'b0;
        step(); step();
        rst = 1'b0;
        vectors++;
        if (bus.o_channel_data !== 64'h0 || bus.o_channel_fresh !== 8'h00 ||
            bus.o_frame_valid !== 1'b0 || bus.o_next_channel !== 8'h00 ||
            bus.o_overrun !== 1'b0 || bus.o_bad_channel !== 1'b0) begin
            $display("FAIL reset: data=%h fresh=%h fv=%b ptr=%h ovr=%b bad=%b, required all 0",
                     bus.o_channel_data, bus.o_channel_fresh, bus.o_frame_valid,
                     bus.o_next_channel, bus.o_overrun, bus.o_bad_channel);
            miscompares++;
        end
`ifdef WAVELET_DEMUX_FRAME_COUNT_EN
        vectors++;
        if (bus.o_frame_count !== 16'd0) begin
            $display("FAIL reset_count: got %0d required 0", bus.o_frame_count);
            miscompares++;
        end
`endif
    endtask

    task automatic test_auto_fill();
        bus.i_auto_scan = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.i_sample_valid = 1'b1;
            bus.i_sample = 8'h10 + 8'(k);
            step();
            vectors++;
            if (bus.o_frame_valid !== (k == 7)) begin
                $display("FAIL auto_fill_fv[%0d]: got %b required %b", k, bus.o_frame_valid, k == 7);
                miscompares++;
            end
        end
        idle();
        vectors++;
        if (bus.o_channel_data !== 64'h1716151413121110 || bus.o_next_channel !== 8'h00 ||
            bus.o_overrun !== 1'b0 || bus.o_channel_fresh !== 8'hFF) begin
            $display("FAIL auto_fill_state: data=%h ptr=%h ovr=%b fresh=%h, required 1716151413121110/00/0/ff",
                     bus.o_channel_data, bus.o_next_channel, bus.o_overrun, bus.o_channel_fresh);
            miscompares++;
        end
        bus.i_frame_ack = 1'b1;
        step();
        idle();
        vectors++;
        if (bus.o_channel_fresh !== 8'h00 || bus.o_frame_valid !== 1'b0) begin
            $display("FAIL auto_fill_ack: fresh=%h fv=%b, required 00/0", bus.o_channel_fresh, bus.o_frame_valid);
            miscompares++;
        end
    endtask

    task automatic test_directed_fill();
        logic [7:0] order [8] = '{8'd7, 8'd3, 8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6};
        bus.i_auto_scan = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.i_sample_valid = 1'b1;
            bus.i_channel = order[k];
            bus.i_sample  = 8'hA0 + order[k];
            step();
            vectors++;
            if (bus.o_frame_valid !== (k == 7)) begin
                $display("FAIL directed_fv[%0d]: got %b required %b", k, bus.o_frame_valid, k == 7);
                miscompares++;
            end
        end
        idle();
        vectors++;
        if (bus.o_channel_fresh !== 8'hFF || bus.o_channel_data !== 64'hA7A6A5A4A3A2A1A0) begin
            $display("FAIL directed_state: fresh=%h data=%h, required ff/a7a6a5a4a3a2a1a0",
                     bus.o_channel_fresh, bus.o_channel_data);
            miscompares++;
        end
        bus.i_frame_ack = 1'b1;
        step();
        idle();
        vectors++;
        if (bus.o_channel_fresh !== 8'h00 || bus.o_frame_valid !== 1'b0) begin
            $display("FAIL directed_ack: fresh=%h fv=%b, required 00/0", bus.o_channel_fresh, bus.o_frame_valid);
            miscompares++;
        end
    endtask

    task automatic test_bad_index();
        vectors++;
        if (bus.o_bad_channel !== 1'b0) begin
            $display("FAIL bad_pre: got %b required 0", bus.o_bad_channel);
            miscompares++;
        end
        bus.i_auto_scan = 1'b0;
        bus.i_sample_valid = 1'b1;
        bus.i_channel = 8'd8;
        bus.i_sample  = 8'h55;
        step();
        idle();
        vectors++;
        if (bus.o_bad_channel !== 1'b1 || bus.o_channel_data !== 64'hA7A6A5A4A3A2A1A0 ||
            bus.o_channel_fresh !== 8'h00 || bus.o_frame_valid !== 1'b0) begin
            $display("FAIL bad_index: bad=%b data=%h fresh=%h fv=%b, required 1/a7a6a5a4a3a2a1a0/00/0",
                     bus.o_bad_channel, bus.o_channel_data, bus.o_channel_fresh, bus.o_frame_valid);
            miscompares++;
        end
    endtask

    task automatic test_collision();
        bus.i_auto_scan = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.i_sample_valid = 1'b1;
            bus.i_sample = 8'h30 + 8'(k);
            step();
        end
        vectors++;
        if (bus.o_frame_valid !== 1'b1) begin
            $display("FAIL collision_full: fv=%b required 1", bus.o_frame_valid);
            miscompares++;
        end
        bus.i_sample_valid = 1'b1;
        bus.i_frame_ack = 1'b1;
        bus.i_sample = 8'h99;
        step();
        idle();
        vectors++;
        if (bus.o_channel_fresh !== 8'h01 || bus.o_frame_valid !== 1'b0 || bus.o_overrun !== 1'b0 ||
            bus.o_channel_data !== 64'h3736353433323199 || bus.o_next_channel !== 8'h01) begin
            $display("FAIL collision: fresh=%h fv=%b ovr=%b data=%h ptr=%h, required 01/0/0/3736353433323199/01",
                     bus.o_channel_fresh, bus.o_frame_valid, bus.o_overrun, bus.o_channel_data, bus.o_next_channel);
            miscompares++;
        end
    endtask

    task automatic test_overrun();
        // ack while not FULL must be ignored
        bus.i_frame_ack = 1'b1;
        step();
        idle();
        vectors++;
        if (bus.o_channel_fresh !== 8'h01) begin
            $display("FAIL ack_ignored: fresh=%h required 01", bus.o_channel_fresh);
            miscompares++;
        end
        bus.i_auto_scan = 1'b0;
        bus.i_sample_valid = 1'b1;
        bus.i_channel = 8'd2;
        bus.i_sample = 8'h11;
        step();
        vectors++;
        if (bus.o_overrun !== 1'b0 || bus.o_next_channel !== 8'h00 || bus.o_channel_fresh !== 8'h05) begin
            $display("FAIL overrun_first: ovr=%b ptr=%h fresh=%h, required 0/00/05",
                     bus.o_overrun, bus.o_next_channel, bus.o_channel_fresh);
            miscompares++;
        end
        bus.i_sample = 8'h22;
        step();
        idle();
        vectors++;
        if (bus.o_overrun !== 1'b1 || bus.o_channel_fresh !== 8'h05 ||
            bus.o_channel_data !== 64'h3736353433223199) begin
            $display("FAIL overrun: ovr=%b fresh=%h data=%h, required 1/05/3736353433223199",
                     bus.o_overrun, bus.o_channel_fresh, bus.o_channel_data);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_frame();
        bus.i_auto_scan = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.i_sample_valid = 1'b1;
            bus.i_sample = 8'hC0 + 8'(k);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (bus.o_channel_data !== 64'h0 || bus.o_channel_fresh !== 8'h00 ||
            bus.o_frame_valid !== 1'b0 || bus.o_next_channel !== 8'h00 ||
            bus.o_overrun !== 1'b0 || bus.o_bad_channel !== 1'b0) begin
            $display("FAIL reset_mid: data=%h fresh=%h fv=%b ptr=%h ovr=%b bad=%b, required all 0",
                     bus.o_channel_data, bus.o_channel_fresh, bus.o_frame_valid,
                     bus.o_next_channel, bus.o_overrun, bus.o_bad_channel);
            miscompares++;
        end
`ifdef WAVELET_DEMUX_FRAME_COUNT_EN
        vectors++;
        if (bus.o_frame_count !== 16'd0) begin
            $display("FAIL reset_mid_count: got %0d required 0", bus.o_frame_count);
            miscompares++;
        end
`endif
        for (int k = 0; k < 8; k++) begin
            bus.i_sample_valid = 1'b1;
            bus.i_sample = 8'hE0 + 8'(k);
            step();
            vectors++;
            if (bus.o_frame_valid !== (k == 7)) begin
                $display("FAIL refill_fv[%0d]: got %b required %b", k, bus.o_frame_valid, k == 7);
                miscompares++;
            end
        end
        idle();
        bus.i_frame_ack = 1'b1;
        step();
        idle();
        vectors++;
        if (bus.o_frame_valid !== 1'b0 || bus.o_channel_fresh !== 8'h00) begin
            $display("FAIL refill_ack: fv=%b fresh=%h, required 0/00", bus.o_frame_valid, bus.o_channel_fresh);
            miscompares++;
        end
`ifdef WAVELET_DEMUX_FRAME_COUNT_EN
        vectors++;
        if (bus.o_frame_count !== 16'd1) begin
            $display("FAIL refill_count: got %0d required 1", bus.o_frame_count);
            miscompares++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_auto_fill();
        test_directed_fill();
        test_bad_index();
        test_collision();
        test_overrun();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
